// File: rtl/rr_demux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rr_demux_sequencer
// Purpose  : Round-robin arbiter that drives the select pair of a 2-to-4
//            demultiplexer. A grant is held until the owning channel signals
//            done or drops its request. Every release is followed by one GAP
//            cycle and one IDLE cycle, so two demux outputs are never active
//            on consecutive cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   4  level-sensitive per-channel requests
//   done       in   1  release strobe, honoured only while a grant is live
//   sel        out  2  registered channel code; sel[1] -> x1, sel[0] -> x2
//   sel_valid  out  1  high while sel is a live grant
//   timeout    out  1  one-cycle pulse on a watchdog-forced release
// Parameters
//   HOLD_MAX   longest grant in cycles before a forced release (2..255);
//              only meaningful when the watchdog is built
// Build option
//   RR_SEQ_WATCHDOG_EN  builds the hold counter and forced release.
//                       Without it a grant may be held indefinitely and
//                       timeout is tied low.
// ============================================================================
module rr_demux_sequencer #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       timeout
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    // Reject an out-of-range HOLD_MAX at elaboration in every build variant.
    if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_check
        $error("rr_demux_sequencer: HOLD_MAX must be in 2..255");
    end

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic       r_sel_valid;
    logic       w_sel_valid_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    logic [1:0] w_pick;
    logic       w_found;
    logic [1:0] w_idx;
    logic       w_user_release;
    logic       w_forced;

    // A release is either an explicit done or the owner abandoning its request.
    assign w_user_release = done | ~req[r_sel];

`ifdef RR_SEQ_WATCHDOG_EN
    // Count value seen in the final allowed GRANT cycle: the count is 0 in
    // the first GRANT cycle, so HOLD_MAX-1 marks the HOLD_MAX-th cycle.
    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_cnt_nxt;

    // A normal release in the limit cycle wins, so no timeout is flagged.
    assign w_forced = (r_state == c_GRANT) && !w_user_release
                      && (r_hold_cnt == c_HOLD_LAST);

    always_comb begin
        w_hold_cnt_nxt = r_hold_cnt;
        if (r_state == c_IDLE) begin
            w_hold_cnt_nxt = 8'd0;
        end else if (r_state == c_GRANT) begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end
`else
    assign w_forced = 1'b0;
`endif

    // Rotating priority scan: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        w_pick  = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // State register together with the registered outputs it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_ptr       <= 2'b00;
            r_sel       <= 2'b00;
            r_sel_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_sel_valid <= w_sel_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (|req) w_state_nxt = c_GRANT;
            c_GRANT: if (w_user_release || w_forced) w_state_nxt = c_GAP;
            c_GAP:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output / datapath next values. sel is never cleared outside reset so
    // the demux select lines stay quiet through GAP and IDLE.
    always_comb begin
        w_sel_nxt       = r_sel;
        w_ptr_nxt       = r_ptr;
        w_sel_valid_nxt = r_sel_valid;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (|req) begin
                    w_sel_nxt       = w_pick;
                    w_sel_valid_nxt = 1'b1;
                end
            end
            c_GRANT: begin
                if (w_user_release || w_forced) begin
                    w_sel_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_sel + 2'd1;
                    w_timeout_nxt   = w_forced;
                end
            end
            c_GAP: begin
                w_sel_valid_nxt = 1'b0;
            end
            default: begin
                w_sel_valid_nxt = 1'b0;
            end
        endcase
    end

    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_demux_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_demux_sequencer
// Purpose  : Directed self-checking bench for rr_demux_sequencer. Inputs are
//            driven and outputs sampled 1 time unit after each rising edge.
//            The DUT is built with HOLD_MAX = 4; the watchdog scenario follows
//            whichever variant RR_SEQ_WATCHDOG_EN selects.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_demux_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] sel;
    logic       sel_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_demux_sequencer #(
        .HOLD_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .sel       (sel),
        .sel_valid (sel_valid),
        .timeout   (timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        repeat (3) tick();
        n_checks++; if (sel !== 2'b00) begin n_errors++; $display("FAIL reset_sel: got %b expected 00", sel); end
        n_checks++; if (sel_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", sel_valid); end
        n_checks++; if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (sel !== 2'b00) begin n_errors++; $display("FAIL first_grant_sel: got %b expected 00", sel); end
        n_checks++; if (sel_valid !== 1'b1) begin n_errors++; $display("FAIL first_grant_valid: got %b expected 1", sel_valid); end
    endtask

    // Grant sequence 0,1,2,3,0 with a two-cycle dead window between grants.
    task automatic test_rotation;
        logic [1:0] cur;
        logic [1:0] nxt;
        cur = 2'd0;
        for (int k = 0; k < 4; k++) begin
            nxt = cur + 2'd1;
            pulse_done();
            n_checks++; if ({sel, sel_valid} !== {cur, 1'b0}) begin n_errors++; $display("FAIL rot_gap[%0d]: got sel=%b valid=%b expected sel=%b valid=0", k, sel, sel_valid, cur); end
            tick();
            n_checks++; if (sel_valid !== 1'b0) begin n_errors++; $display("FAIL rot_idle[%0d]: got valid=%b expected 0", k, sel_valid); end
            tick();
            n_checks++; if ({sel, sel_valid} !== {nxt, 1'b1}) begin n_errors++; $display("FAIL rot_grant[%0d]: got sel=%b valid=%b expected sel=%b valid=1", k, sel, sel_valid, nxt); end
            cur = nxt;
        end
    endtask

    task automatic test_skip_wrap;
        // From channel 0 walk forward to a grant on channel 2.
        pulse_done(); tick(); tick();
        n_checks++; if ({sel, sel_valid} !== 3'b011) begin n_errors++; $display("FAIL skip_pre1: got sel=%b valid=%b expected sel=01 valid=1", sel, sel_valid); end
        pulse_done(); tick(); tick();
        n_checks++; if ({sel, sel_valid} !== 3'b101) begin n_errors++; $display("FAIL skip_pre2: got sel=%b valid=%b expected sel=10 valid=1", sel, sel_valid); end
        // Release channel 2 while narrowing requests to channels 0 and 1.
        req = 4'b0011;
        pulse_done();
        n_checks++; if ({sel, sel_valid} !== 3'b100) begin n_errors++; $display("FAIL skip_gap: got sel=%b valid=%b expected sel=10 valid=0", sel, sel_valid); end
        tick(); tick();
        n_checks++; if ({sel, sel_valid} !== 3'b001) begin n_errors++; $display("FAIL skip_wrap0: got sel=%b valid=%b expected sel=00 valid=1", sel, sel_valid); end
        pulse_done(); tick(); tick();
        n_checks++; if ({sel, sel_valid} !== 3'b011) begin n_errors++; $display("FAIL skip_then1: got sel=%b valid=%b expected sel=01 valid=1", sel, sel_valid); end
    endtask

    // Channel 1 abandons; ptr must become 2, observed via req = 0111.
    task automatic test_abandon;
        req = 4'b0001;
        tick();
        n_checks++; if ({sel, sel_valid} !== 3'b010) begin n_errors++; $display("FAIL abandon_gap: got sel=%b valid=%b expected sel=01 valid=0", sel, sel_valid); end
        req = 4'b0111;
        tick();
        n_checks++; if ({sel, sel_valid} !== 3'b010) begin n_errors++; $display("FAIL abandon_idle: got sel=%b valid=%b expected sel=01 valid=0", sel, sel_valid); end
        tick();
        n_checks++; if ({sel, sel_valid} !== 3'b101) begin n_errors++; $display("FAIL abandon_ptr: got sel=%b valid=%b expected sel=10 valid=1", sel, sel_valid); end
    endtask

    task automatic test_reset_mid_grant;
        req = 4'b1000;
        pulse_done(); tick(); tick();
        n_checks++; if ({sel, sel_valid} !== 3'b111) begin n_errors++; $display("FAIL midrst_pre: got sel=%b valid=%b expected sel=11 valid=1", sel, sel_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({sel, sel_valid} !== 3'b000) begin n_errors++; $display("FAIL midrst_async: got sel=%b valid=%b expected sel=00 valid=0", sel, sel_valid); end
        tick(); tick();
        n_checks++; if ({sel, sel_valid, timeout} !== 4'b0000) begin n_errors++; $display("FAIL midrst_hold: got sel=%b valid=%b timeout=%b expected 00/0/0", sel, sel_valid, timeout); end
        rst_n = 1'b1;
        tick();
        n_checks++; if ({sel, sel_valid} !== 3'b111) begin n_errors++; $display("FAIL midrst_regrant: got sel=%b valid=%b expected sel=11 valid=1", sel, sel_valid); end
    endtask

    task automatic test_watchdog;
        // Release channel 3 (ptr -> 0) and get a grant on channel 0.
        req = 4'b0011;
        pulse_done(); tick(); tick();
        n_checks++; if ({sel, sel_valid} !== 3'b001) begin n_errors++; $display("FAIL wd_grant0: got sel=%b valid=%b expected sel=00 valid=1", sel, sel_valid); end
`ifdef RR_SEQ_WATCHDOG_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({sel_valid, timeout} !== 2'b10) begin n_errors++; $display("FAIL wd_hold[%0d]: got valid=%b timeout=%b expected 1/0", i, sel_valid, timeout); end
        end
        tick();
        n_checks++; if ({sel, sel_valid, timeout} !== 4'b0001) begin n_errors++; $display("FAIL wd_force: got sel=%b valid=%b timeout=%b expected 00/0/1", sel, sel_valid, timeout); end
        tick();
        n_checks++; if ({sel_valid, timeout} !== 2'b00) begin n_errors++; $display("FAIL wd_pulse_end: got valid=%b timeout=%b expected 0/0", sel_valid, timeout); end
        tick();
        n_checks++; if ({sel, sel_valid} !== 3'b011) begin n_errors++; $display("FAIL wd_next: got sel=%b valid=%b expected sel=01 valid=1", sel, sel_valid); end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            n_checks++; if ({sel, sel_valid, timeout} !== 4'b0010) begin n_errors++; $display("FAIL nowd_hold[%0d]: got sel=%b valid=%b timeout=%b expected 00/1/0", i, sel, sel_valid, timeout); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_abandon();
        test_reset_mid_grant();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
